// File: rtl/mrd_fsmsource.sv
// Read side of the 7-bank memory-reorder buffer: on Source-state entry, reads one
// frame of N samples bank round-robin and emits it as a sop/eop sample stream.
module mrd_fsmsource #(
    parameter int wADDR  = 8,
    parameter int wDATA  = 36,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           fsm,
    input  logic [11:0]          dftpts,
    output logic [7*wADDR-1:0]   rdaddr,
    output logic [6:0]           rden,
    input  logic [7*wDATA-1:0]   rddata,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [wDATA-1:0]     out_data,
    output logic                 source_end,
    output logic                 overTime
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [2:0]  FSM_SOURCE = 3'd5;
    localparam logic [31:0] MAX_N      = 32'(7 * (2 ** wADDR));
    localparam logic [6:0]  BANK0_HOT  = 7'b1000000;

    state_t           state, state_nx;
    logic [2:0]       fsm_d;
    logic             in_source, start, abort, issue, last_issue;
    logic [11:0]      n_lat, cnt, cnt_ot;
    logic [2:0]       bank_pre;
    logic [wADDR-1:0] addr_pre, addr_q;
    logic [6:0]       rden_q;
    logic [RD_LAT:0]  dl_valid, dl_first, dl_last;
    logic [2:0]       dl_bank [RD_LAT+1];
    logic [wDATA-1:0] sel_data;

    assign in_source  = (fsm == FSM_SOURCE);
    assign start      = in_source && (fsm_d != FSM_SOURCE);
    assign abort      = ((state == ISSUE) || (state == DRAIN)) && !in_source;
    assign issue      = (state == ISSUE) && in_source;
    assign last_issue = (cnt == n_lat - 12'd1);

    assign rdaddr = {7{addr_q}};
    assign rden   = rden_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (dftpts != 12'd0) ? ISSUE : DONE;
            ISSUE: begin
                if (abort)           state_nx = IDLE;
                else if (last_issue) state_nx = DRAIN;
            end
            DRAIN: begin
                if (abort)                                    state_nx = IDLE;
                else if (dl_valid[RD_LAT] && dl_last[RD_LAT]) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned b = 0; b < 7; b++) begin
            if (dl_bank[RD_LAT] == 3'(b)) sel_data = rddata[(6-b)*wDATA +: wDATA];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fsm_d      <= '0;
            n_lat      <= '0;
            cnt        <= '0;
            bank_pre   <= '0;
            addr_pre   <= '0;
            addr_q     <= '0;
            rden_q     <= '0;
            cnt_ot     <= '0;
            overTime   <= 1'b0;
            source_end <= 1'b0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_data   <= '0;
        end else begin
            state <= state_nx;
            fsm_d <= fsm;

            if ((state == IDLE) && start)
                n_lat <= ({20'd0, dftpts} > MAX_N) ? MAX_N[11:0] : dftpts;

            // Pre-counters only advance while issuing; any other cycle (incl. abort) clears them.
            if (issue) begin
                cnt <= cnt + 12'd1;
                if (bank_pre == 3'd6) begin
                    bank_pre <= '0;
                    addr_pre <= addr_pre + 1'b1;
                end else begin
                    bank_pre <= bank_pre + 3'd1;
                end
            end else begin
                cnt      <= '0;
                bank_pre <= '0;
                addr_pre <= '0;
            end

            addr_q <= addr_pre;
            rden_q <= issue ? (BANK0_HOT >> bank_pre) : '0;

            // Counting on the registered fsm puts the pulse 2049 cycles after entry.
            cnt_ot   <= (fsm_d == FSM_SOURCE) ? cnt_ot + 12'd1 : '0;
            overTime <= (cnt_ot == 12'd2047);

            source_end <= (state == DONE);

            out_valid <= !abort && dl_valid[RD_LAT];
            out_sop   <= !abort && dl_valid[RD_LAT] && dl_first[RD_LAT];
            out_eop   <= !abort && dl_valid[RD_LAT] && dl_last[RD_LAT];
            if (dl_valid[RD_LAT]) out_data <= sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            dl_valid <= '0;
            dl_first <= '0;
            dl_last  <= '0;
        end else begin
            dl_valid <= {dl_valid[RD_LAT-1:0], issue};
            dl_first <= {dl_first[RD_LAT-1:0], issue && (cnt == 12'd0)};
            dl_last  <= {dl_last[RD_LAT-1:0], issue && last_issue};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= RD_LAT; i++) dl_bank[i] <= '0;
        end else begin
            dl_bank[0] <= bank_pre;
            for (int unsigned i = 1; i <= RD_LAT; i++) dl_bank[i] <= dl_bank[i-1];
        end
    end

endmodule

// File: tb/tb_mrd_fsmsource.sv
// Directed bench for mrd_fsmsource with a 2-cycle-latency RAM model returning
// {bank, addr} per bank so every output sample identifies its source.
module tb_mrd_fsmsource;

    logic          clk;
    logic          rst_n;
    logic [2:0]    fsm;
    logic [11:0]   dftpts;
    logic [55:0]   rdaddr;
    logic [6:0]    rden;
    logic [251:0]  rddata;
    logic          out_valid, out_sop, out_eop, source_end, overTime;
    logic [35:0]   out_data;

    int errors = 0;
    int checks = 0;

    logic [55:0] ap0, ap1;
    logic [6:0]  bank0_hot;

    mrd_fsmsource #(.wADDR(8), .wDATA(36), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .fsm(fsm), .dftpts(dftpts),
        .rdaddr(rdaddr), .rden(rden), .rddata(rddata),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .source_end(source_end), .overTime(overTime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ap0 <= rdaddr;
        ap1 <= ap0;
    end

    always_comb begin
        rddata = '0;
        for (int unsigned b = 0; b < 7; b++)
            rddata[(6-b)*36 +: 36] = {25'd0, 3'(b), ap1[(6-b)*8 +: 8]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enter Source at cycle 0 and check every output cycle by cycle until ncyc.
    task automatic do_frame(input int dft, input int n, input int ncyc, input string nm);
        logic [6:0] exp_rden;
        logic       ev;
        fsm    = 3'd5;
        dftpts = 12'(dft);
        for (int c = 1; c <= ncyc; c++) begin
            step();
            exp_rden = (n > 0 && c >= 2 && c <= n + 1) ? (bank0_hot >> ((c - 2) % 7)) : 7'd0;
            chk($sformatf("%s_rden@%0d", nm, c), 64'(rden), 64'(exp_rden));
            if (exp_rden != 7'd0)
                chk($sformatf("%s_rdaddr@%0d", nm, c), 64'(rdaddr), 64'({7{8'((c - 2) / 7)}}));
            ev = (n > 0 && c >= 5 && c <= n + 4);
            chk($sformatf("%s_valid@%0d", nm, c), 64'(out_valid), 64'(ev));
            chk($sformatf("%s_sop@%0d", nm, c), 64'(out_sop), 64'(n > 0 && c == 5));
            chk($sformatf("%s_eop@%0d", nm, c), 64'(out_eop), 64'(n > 0 && c == n + 4));
            if (ev)
                chk($sformatf("%s_data@%0d", nm, c), 64'(out_data),
                    64'(((c - 5) % 7) * 256 + (c - 5) / 7));
            chk($sformatf("%s_end@%0d", nm, c), 64'(source_end),
                64'(c == ((n > 0) ? n + 5 : 2)));
            chk($sformatf("%s_ot@%0d", nm, c), 64'(overTime), 64'(c == 2049));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bank0_hot = 7'b1000000;
        rst_n  = 1'b0;
        fsm    = 3'd0;
        dftpts = 12'd0;
        step(); step(); step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rden", 64'(rden), 64'd0);
        chk("rst_rdaddr", 64'(rdaddr), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_end", 64'(source_end), 64'd0);
        chk("rst_ot", 64'(overTime), 64'd0);
        rst_n = 1'b1;
        step(); step();

        do_frame(14, 14, 22, "n14");
        fsm = 3'd0; step(); step();

        do_frame(1, 1, 9, "n1");
        fsm = 3'd0; step();

        do_frame(0, 0, 6, "n0");
        fsm = 3'd0; step();

        // Abort: leave Source after 8 issues, then re-enter with N=7.
        fsm = 3'd5; dftpts = 12'd20;
        for (int c = 1; c <= 9; c++) step();
        chk("ab_rden_last", 64'(rden), 64'(bank0_hot));
        chk("ab_valid_pre", 64'(out_valid), 64'd1);
        chk("ab_data_pre", 64'(out_data), 64'h400);
        fsm = 3'd0;
        for (int c = 10; c <= 21; c++) begin
            step();
            chk($sformatf("ab_rden@%0d", c), 64'(rden), 64'd0);
            chk($sformatf("ab_valid@%0d", c), 64'(out_valid), 64'd0);
            chk($sformatf("ab_eop@%0d", c), 64'(out_eop), 64'd0);
            chk($sformatf("ab_end@%0d", c), 64'(source_end), 64'd0);
        end
        do_frame(7, 7, 14, "re7");
        fsm = 3'd0; step();

        do_frame(3, 3, 2100, "h2100");
        fsm = 3'd0; step();
        do_frame(3, 3, 2000, "h2000");
        fsm = 3'd0; step();

        do_frame(1200, 1200, 1208, "b2b_a");
        fsm = 3'd0; step();
        do_frame(1200, 1200, 1208, "b2b_b");
        fsm = 3'd0; step();

        do_frame(4000, 1792, 1800, "clamp_a");
        fsm = 3'd0; step();
        do_frame(4000, 1792, 1800, "clamp_b");
        fsm = 3'd0; step();

        // Reset in the middle of a streaming frame.
        fsm = 3'd5; dftpts = 12'd14;
        for (int c = 1; c <= 7; c++) step();
        chk("mr_valid_pre", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        step();
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_rden", 64'(rden), 64'd0);
        chk("mr_data", 64'(out_data), 64'd0);
        fsm = 3'd0; rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("mr_post_valid@%0d", c), 64'(out_valid), 64'd0);
            chk($sformatf("mr_post_end@%0d", c), 64'(source_end), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mrd_fsmsource.md
Name: mrd_FSMsource

Overview:
- Read-side counterpart of the 7-bank memory-reorder buffer's sink writer.
- When the top-level memory FSM enters the Source state, it reads one frame of N samples from the 7 single-port-read RAM banks in bank round-robin order and emits them as a sample stream with sop/eop.
- Sample k lives in bank (k mod 7) at address floor(k/7); bank 0 is the MSB of the one-hot enable.
- Reports frame completion and a Source-state timeout back to the FSM.

Parameters:
- wADDR, 8, bank address width.
- wDATA, 36, sample width per bank (packed real/imag).
- RD_LAT, 2, RAM read latency in cycles, from registered rdaddr/rden to valid rddata (1..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- fsm  in  3  memory FSM state; Source = 3'd5.
- dftpts  in  12  frame length N, sampled at Source entry.
- rdaddr  out  7*wADDR  per-bank read address; bank b occupies bits [(6-b)*wADDR +: wADDR].
- rden  out  7  one-hot read enable; bit 6 = bank 0.
- rddata  in  7*wDATA  per-bank read data; same packing as rdaddr.
- out_valid  out  1  output sample valid.
- out_sop  out  1  first sample of frame.
- out_eop  out  1  last sample of frame.
- out_data  out  wDATA  output sample.
- source_end  out  1  one-cycle frame-done pulse.
- overTime  out  1  Source-state timeout flag.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE.
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Entry detect: fsm_d is fsm registered. start = (fsm==5) && (fsm_d!=5).
- On start, latch N = min(dftpts, 7*2^wADDR) as a 12-bit compare. The block restarts only on a fresh entry; holding fsm==5 never restarts it.
- States:
  - IDLE: on start, go to ISSUE if N!=0, else go to DONE.
  - ISSUE: one read per cycle. Pre-counters are cnt (0..N-1), bank_pre (0..6) and addr_pre. bank_pre wraps 6->0, and addr_pre increments on that wrap. Go to DRAIN after issuing cnt==N-1.
  - DRAIN: wait for the last sample to leave the pipeline, then go to DONE.
  - DONE: pulse source_end for 1 cycle, then go to IDLE.
- Issue pipeline:
  - The pre-counters are registered 1 cycle into rdaddr and rden. All 7 rdaddr fields carry the same addr_pre.
  - rden is the one-hot of bank_pre, and is 0 when not issuing.
  - Bank index, valid, first and last flags travel through a (1+RD_LAT)-deep delay line.
  - out_data is registered from the rddata field of the delayed bank index. out_valid, out_sop and out_eop are registered alongside it.
- Latency, with fsm first ==5 at cycle 0:
  - start is detected at cycle 1.
  - First rden at cycle 2.
  - First out_valid at cycle 3+RD_LAT (cycle 5 at default).
- Output stream: exactly N contiguous out_valid cycles, no gaps. out_sop on the first, out_eop on the last; for N==1 both occur in the same cycle.
- source_end: asserted the cycle after out_eop. For N==0 it is asserted the cycle after start, with no out_valid.
- Abort: if fsm leaves 5 while in ISSUE or DRAIN:
  - Next cycle: rden=0, pre-counters clear, and all delay-line valids clear.
  - out_valid drops within 1 cycle.
  - No out_eop and no source_end. Return to IDLE.
- overTime:
  - cnt_ot counts while fsm==5 and clears otherwise (12 bit).
  - overTime is registered as (cnt_ot==2047), so it is a single-cycle pulse.
  - Independent of the data state machine.
- When out_valid=0, out_data holds its last value. Don't-care for checking.
- Reset mid-frame: everything clears next edge. No outputs are asserted until a new Source entry.

Test Plan:
- N=14, RD_LAT=2, rddata = {bank, addr} pattern -> rden sequence 1000000, 0100000 … 0000001 twice, starting cycle 2. rdaddr 0 then 1. out_valid cycles 5..18, out_data in order k=0..13, sop@5, eop@18, source_end@19.
- N=1 -> single out_valid with sop=eop=1 at cycle 5, source_end at 6.
- N=0 -> no rden and no out_valid; source_end at cycle 2.
- N=20, fsm drops to 0 after 8 issues -> rden=0 next cycle, out_valid stops within 1 cycle, no eop and no source_end. Re-entry with N=7 then yields a clean frame with sop at the first sample.
- fsm held at 5 for 2100 cycles with N=3 -> exactly one frame, and overTime pulses once at cycle 2049 after entry. fsm held at 5 for 2000 cycles -> no overTime.
- Back-to-back frames N=1200, fsm 5 -> 0 for 1 cycle -> 5 -> two identical streams, and addr wraps correctly past 171. Same test with dftpts=4000 -> clamps to 1792 samples.
